// File: rtl/jk_pkg.sv
// Shared encodings for the JK register bank: command opcodes, per-bit JK codes, sweep FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jk_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_JK      = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_CLR_CNT = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  // Per-bit {j,k} codes
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TOG  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/jk_channel.sv
// One WIDTH-bit JK register with a saturating change counter and a registered change flag.
// Latency: q/cnt/chg update on the edge where an enable is high.
// Backpressure: none; enables are already qualified by the parent's accept.
// Ports: clk, reset (sync, active-high); jk_en/load_en/clr_cnt_en command strobes;
//   sweep_clr forces q=RESET_VAL and cnt=0; j/k data; q, cnt, chg outputs from flops.
module jk_channel
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jk_en,
  input  logic             load_en,
  input  logic             clr_cnt_en,
  input  logic             sweep_clr,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt,
  output logic             chg
);

  logic [WIDTH-1:0] q_nxt;
  logic             changed;

  always_comb begin
    q_nxt = q;
    if (sweep_clr) begin
      q_nxt = RESET_VAL;
    end else if (load_en) begin
      q_nxt = j;
    end else if (jk_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          HOLD:    q_nxt[i] = q[i];
          RST:     q_nxt[i] = 1'b0;
          SET:     q_nxt[i] = 1'b1;
          TOG:     q_nxt[i] = ~q[i];
          default: q_nxt[i] = q[i];
        endcase
      end
    end
  end

  assign changed = (q_nxt != q);

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= RESET_VAL;
      cnt <= '0;
      chg <= 1'b0;
    end else begin
      q   <= q_nxt;
      chg <= changed;
      if (sweep_clr || clr_cnt_en) begin
        cnt <= '0;
      end else if ((jk_en || load_en) && changed && (cnt != {CNT_W{1'b1}})) begin
        // Counter sticks at all-ones rather than wrapping
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of CHANNELS JK registers with command port, sequential clear sweep and registered read port.
// Latency: commands take effect on the accept edge; rd_q/rd_cnt one cycle; q_all zero.
// Backpressure: cmd_ready low for the CHANNELS cycles of a clear sweep; commands stall.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_ch/cmd_j/cmd_k command;
//   clr_req starts a sweep; rd_ch -> rd_q/rd_cnt; q_all, chg_pulse, busy status.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CH_W      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [WIDTH-1:0]          cmd_j,
  input  logic [WIDTH-1:0]          cmd_k,
  input  logic                      clr_req,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [WIDTH-1:0]          rd_q,
  output logic [CNT_W-1:0]          rd_cnt,
  output logic [CHANNELS*WIDTH-1:0] q_all,
  output logic [CHANNELS-1:0]       chg_pulse,
  output logic                      busy
);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   idx, idx_nxt;
  logic              accept;
  logic [CHANNELS-1:0] jk_en, load_en, clr_cnt_en, sweep_clr;
  logic [WIDTH-1:0]  q_arr   [CHANNELS];
  logic [CNT_W-1:0]  cnt_arr [CHANNELS];
  logic [WIDTH-1:0]  rd_q_nxt;
  logic [CNT_W-1:0]  rd_cnt_nxt;

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sweep_clr = '0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (clr_req) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          if (idx == CH_W'(c)) sweep_clr[c] = 1'b1;
        end
        // clr_req is deliberately not looked at here: no restart mid-sweep
        if (idx == CH_W'(CHANNELS - 1)) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + CH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command decode; an out-of-range cmd_ch matches no channel and is silently dropped
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    jk_en      = '0;
    load_en    = '0;
    clr_cnt_en = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && (cmd_ch == CH_W'(c))) begin
        case (cmd_op)
          OP_JK:      jk_en[c]      = 1'b1;
          OP_LOAD:    load_en[c]    = 1'b1;
          OP_CLR_CNT: clr_cnt_en[c] = 1'b1;
          OP_NOP:     ;
          default:    ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    jk_channel #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .jk_en      (jk_en[g]),
      .load_en    (load_en[g]),
      .clr_cnt_en (clr_cnt_en[g]),
      .sweep_clr  (sweep_clr[g]),
      .j          (cmd_j),
      .k          (cmd_k),
      .q          (q_arr[g]),
      .cnt        (cnt_arr[g]),
      .chg        (chg_pulse[g])
    );
    assign q_all[g*WIDTH +: WIDTH] = q_arr[g];
  end

  // Read port: out-of-range rd_ch returns zero
  always_comb begin
    rd_q_nxt   = '0;
    rd_cnt_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_q_nxt   = q_arr[c];
        rd_cnt_nxt = cnt_arr[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      rd_cnt <= '0;
    end else begin
      rd_q   <= rd_q_nxt;
      rd_cnt <= rd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: a default instance (8b x 4ch, 16b counters) and a
// second instance (8b x 5ch, 2b counters, RESET_VAL=8'h5A) for saturation and range edges.
// Checks are taken 1 time unit after each rising edge.
module tb_jk_reg_bank;
  import jk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: defaults
  logic        a_valid, a_ready, a_clr, a_busy;
  logic [1:0]  a_op, a_ch, a_rd_ch;
  logic [7:0]  a_j, a_k, a_rd_q;
  logic [15:0] a_rd_cnt;
  logic [31:0] a_q_all;
  logic [3:0]  a_chg;

  // Instance B: 5 channels, 2-bit counters, non-zero reset value
  logic        b_valid, b_ready, b_clr, b_busy;
  logic [1:0]  b_op;
  logic [2:0]  b_ch, b_rd_ch;
  logic [7:0]  b_j, b_k, b_rd_q;
  logic [1:0]  b_rd_cnt;
  logic [39:0] b_q_all;
  logic [4:0]  b_chg;

  int total = 0;
  int bad   = 0;

  jk_reg_bank u_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
    .cmd_ch(a_ch), .cmd_j(a_j), .cmd_k(a_k), .clr_req(a_clr), .rd_ch(a_rd_ch),
    .rd_q(a_rd_q), .rd_cnt(a_rd_cnt), .q_all(a_q_all), .chg_pulse(a_chg), .busy(a_busy)
  );

  jk_reg_bank #(.WIDTH(8), .CHANNELS(5), .CNT_W(2), .RESET_VAL(8'h5A)) u_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
    .cmd_ch(b_ch), .cmd_j(b_j), .cmd_k(b_k), .clr_req(b_clr), .rd_ch(b_rd_ch),
    .rd_q(b_rd_q), .rd_cnt(b_rd_cnt), .q_all(b_q_all), .chg_pulse(b_chg), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input logic [1:0] op, input logic [1:0] ch,
                       input logic [7:0] j, input logic [7:0] k);
    a_valid = 1'b1; a_op = op; a_ch = ch; a_j = j; a_k = k;
    tick();
    a_valid = 1'b0; a_op = OP_NOP;
  endtask

  task automatic cmd_b(input logic [1:0] op, input logic [2:0] ch,
                       input logic [7:0] j, input logic [7:0] k);
    b_valid = 1'b1; b_op = op; b_ch = ch; b_j = j; b_k = k;
    tick();
    b_valid = 1'b0; b_op = OP_NOP;
  endtask

  task automatic read_a(input logic [1:0] ch);
    a_rd_ch = ch;
    tick();
  endtask

  task automatic read_b(input logic [2:0] ch);
    b_rd_ch = ch;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    a_valid = 1'b0; a_op = OP_NOP; a_ch = '0; a_j = '0; a_k = '0; a_clr = 1'b0; a_rd_ch = '0;
    b_valid = 1'b0; b_op = OP_NOP; b_ch = '0; b_j = '0; b_k = '0; b_clr = 1'b0; b_rd_ch = '0;
    tick();
    tick();

    // 1: reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_q_all", a_q_all, 32'h0);
    chk("rst_chg", a_chg, 0);
    chk("rst_rd_q", a_rd_q, 0);
    chk("rst_rd_cnt", a_rd_cnt, 0);
    chk("rst_b_q_all", b_q_all, {5{8'h5A}});
    chk("rst_b_rd_q", b_rd_q, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      read_a(2'(c));
      chk($sformatf("rd_q_ch%0d", c), a_rd_q, 0);
      chk($sformatf("rd_cnt_ch%0d", c), a_rd_cnt, 0);
    end

    // 2: JK set/reset then toggle on ch1
    cmd_a(OP_JK, 2'd1, 8'hF0, 8'h0F);
    chk("jk1_q", a_q_all[15:8], 8'hF0);
    chk("jk1_chg", a_chg, 4'b0010);
    cmd_a(OP_JK, 2'd1, 8'hFF, 8'hFF);
    chk("jk2_q", a_q_all[15:8], 8'h0F);
    chk("jk2_chg", a_chg, 4'b0010);
    read_a(2'd1);
    chk("jk_chg_idle", a_chg, 0);
    chk("jk_rd_q", a_rd_q, 8'h0F);
    chk("jk_rd_cnt", a_rd_cnt, 2);

    // 3: LOAD twice, CLR_CNT, NOP on ch2
    cmd_a(OP_LOAD, 2'd2, 8'hAA, 8'h00);
    chk("ld1_q", a_q_all[23:16], 8'hAA);
    chk("ld1_chg", a_chg, 4'b0100);
    cmd_a(OP_LOAD, 2'd2, 8'hAA, 8'h55);
    chk("ld2_chg", a_chg, 0);
    read_a(2'd2);
    chk("ld_rd_cnt", a_rd_cnt, 1);
    cmd_a(OP_CLR_CNT, 2'd2, 8'h00, 8'h00);
    read_a(2'd2);
    chk("clrcnt_rd_cnt", a_rd_cnt, 0);
    chk("clrcnt_rd_q", a_rd_q, 8'hAA);
    cmd_a(OP_NOP, 2'd2, 8'hFF, 8'hFF);
    chk("nop_q_all", a_q_all, 32'h00AA0F00);

    // 4: 2-bit counter saturation on instance B, ch0 toggles 5A<->A5
    for (int i = 0; i < 5; i++) begin
      cmd_b(OP_JK, 3'd0, 8'hFF, 8'hFF);
      chk($sformatf("b_tog%0d_q", i), b_q_all[7:0], (i % 2 == 0) ? 8'hA5 : 8'h5A);
    end
    read_b(3'd0);
    chk("b_sat_cnt", b_rd_cnt, 3);
    chk("b_sat_q", b_rd_q, 8'hA5);
    // Out-of-range channel: accepted, no effect
    chk("b_oor_ready", b_ready, 1);
    cmd_b(OP_JK, 3'd5, 8'hFF, 8'hFF);
    chk("b_oor_q_all", b_q_all, {{4{8'h5A}}, 8'hA5});
    chk("b_oor_chg", b_chg, 0);
    read_b(3'd5);
    chk("b_oor_rd_q", b_rd_q, 0);
    chk("b_oor_rd_cnt", b_rd_cnt, 0);
    // Sweep on a non-power-of-2 bank lasts 5 cycles
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n = 0;
    while (b_busy && n < 20) begin
      n++;
      tick();
    end
    chk("b_sweep_len", n, 5);
    chk("b_sweep_q_all", b_q_all, {5{8'h5A}});
    read_b(3'd0);
    chk("b_sweep_cnt", b_rd_cnt, 0);

    // 5: clr_req with a JK on ch3 in the same cycle; stalled command; ignored mid-sweep clr_req
    a_clr = 1'b1;
    a_valid = 1'b1; a_op = OP_JK; a_ch = 2'd3; a_j = 8'h3C; a_k = 8'h00;
    tick();
    a_clr = 1'b0;
    chk("sw0_q3", a_q_all[31:24], 8'h3C);
    chk("sw0_busy", a_busy, 1);
    chk("sw0_ready", a_ready, 0);
    chk("sw0_chg", a_chg, 4'b1000);
    a_ch = 2'd0; a_j = 8'hFF; a_k = 8'h00;
    tick();
    chk("sw1_busy", a_busy, 1);
    chk("sw1_ready", a_ready, 0);
    chk("sw1_chg", a_chg, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("sw2_busy", a_busy, 1);
    chk("sw2_chg", a_chg, 4'b0010);
    tick();
    chk("sw3_busy", a_busy, 1);
    chk("sw3_ready", a_ready, 0);
    chk("sw3_chg", a_chg, 4'b0100);
    a_valid = 1'b0; a_op = OP_NOP;
    tick();
    chk("sw4_busy", a_busy, 0);
    chk("sw4_ready", a_ready, 1);
    chk("sw4_chg", a_chg, 4'b1000);
    chk("sw4_q_all", a_q_all, 32'h0);
    tick();
    chk("sw5_busy", a_busy, 0);
    chk("sw5_q_all", a_q_all, 32'h0);
    read_a(2'd3);
    chk("sw_rd_cnt3", a_rd_cnt, 0);

    // clr_req held: one command accepted in the IDLE cycle between sweeps
    a_clr = 1'b1;
    a_valid = 1'b1; a_op = OP_LOAD; a_ch = 2'd0; a_j = 8'h77; a_k = 8'h00;
    tick();
    chk("held0_busy", a_busy, 1);
    chk("held0_q0", a_q_all[7:0], 8'h77);
    a_j = 8'h66;
    for (int i = 0; i < 4; i++) tick();
    chk("held_idle_busy", a_busy, 0);
    chk("held_idle_ready", a_ready, 1);
    tick();
    chk("held_restart_busy", a_busy, 1);
    chk("held_restart_q0", a_q_all[7:0], 8'h66);
    a_clr = 1'b0; a_valid = 1'b0; a_op = OP_NOP;
    for (int i = 0; i < 4; i++) tick();
    chk("held_end_busy", a_busy, 0);
    chk("held_end_q_all", a_q_all, 32'h0);

    // 6: reset during the second sweep cycle
    cmd_a(OP_LOAD, 2'd3, 8'h11, 8'h00);
    chk("pre_rst_q3", a_q_all[31:24], 8'h11);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", a_busy, 0);
    chk("midrst_ready", a_ready, 1);
    chk("midrst_q_all", a_q_all, 32'h0);
    chk("midrst_chg", a_chg, 0);
    reset = 1'b0;
    read_a(2'd3);
    chk("midrst_rd_q3", a_rd_q, 0);
    chk("midrst_rd_cnt3", a_rd_cnt, 0);
    tick();
    chk("midrst_after_busy", a_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
